// File: rtl/mmio_io_ctrl_if.sv
// Core/UART-facing signal bundle for mmio_io_ctrl. The master side is the
// core memory stage plus the UART; the slave side is the MMIO block itself.
interface mmio_io_ctrl_if;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_we;
  logic        mmio_re;
  logic        inst_retired;
  logic [31:0] mmio_rdata;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  modport master (
    output mmio_addr, mmio_wdata, mmio_we, mmio_re, inst_retired,
    output uart_rx_data, uart_rx_valid, uart_tx_ready,
    input  mmio_rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
  );

  modport slave (
    input  mmio_addr, mmio_wdata, mmio_we, mmio_re, inst_retired,
    input  uart_rx_data, uart_rx_valid, uart_tx_ready,
    output mmio_rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// MMIO window at MMIO_BASE: UART RX FIFO, TX holding register, cycle and
// retired-instruction counters, with registered (1-cycle) read data.
module mmio_io_ctrl #(
  parameter int unsigned RX_FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE     = 32'h8000_0000
) (
  input logic           clk,
  input logic           rst_n,
  mmio_io_ctrl_if.slave bus
);
  localparam int unsigned PW = $clog2(RX_FIFO_DEPTH);

  typedef enum logic { TX_EMPTY, TX_FULL } tx_state_t;

  tx_state_t   tx_state, tx_next;
  logic        tx_load;
  logic [7:0]  tx_data;

  logic [7:0]  rx_mem [RX_FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        rx_empty, rx_full, rx_push, rx_pop;

  logic [31:0] cycle_cnt, inst_cnt;
  logic [31:0] rd_val, rdata;

  logic hit_status, hit_rx, hit_tx, hit_cyc, hit_inst, hit_crst;
  logic unused_wdata_hi;

  assign hit_status = (bus.mmio_addr == MMIO_BASE + 32'h00);
  assign hit_rx     = (bus.mmio_addr == MMIO_BASE + 32'h04);
  assign hit_tx     = (bus.mmio_addr == MMIO_BASE + 32'h08);
  assign hit_cyc    = (bus.mmio_addr == MMIO_BASE + 32'h10);
  assign hit_inst   = (bus.mmio_addr == MMIO_BASE + 32'h14);
  assign hit_crst   = (bus.mmio_addr == MMIO_BASE + 32'h18);

  assign unused_wdata_hi = ^bus.mmio_wdata[31:8];

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign rx_empty = (wr_ptr == rd_ptr);
  assign rx_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rx_push  = bus.uart_rx_valid && !rx_full;
  assign rx_pop   = bus.mmio_re && hit_rx && !rx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rx_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (rx_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[wr_ptr[PW-1:0]] <= bus.uart_rx_data;
  end

  // A store is only taken while empty, so a store on the handshake edge is lost.
  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_EMPTY: begin
        if (bus.mmio_we && hit_tx) begin
          tx_next = TX_FULL;
          tx_load = 1'b1;
        end
      end
      TX_FULL: begin
        if (bus.uart_tx_ready) tx_next = TX_EMPTY;
      end
      default: tx_next = TX_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_EMPTY;
      tx_data  <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_load) tx_data <= bus.mmio_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else if (bus.mmio_we && hit_crst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      inst_cnt  <= inst_cnt + {31'b0, bus.inst_retired};
    end
  end

  always_comb begin
    rd_val = '0;
    if (hit_status)             rd_val = {30'b0, !rx_empty, (tx_state == TX_EMPTY)};
    else if (hit_rx && !rx_empty) rd_val = {24'b0, rx_mem[rd_ptr[PW-1:0]]};
    else if (hit_cyc)           rd_val = cycle_cnt;
    else if (hit_inst)          rd_val = inst_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rdata <= '0;
    else if (bus.mmio_re) rdata <= rd_val;
  end

  assign bus.mmio_rdata    = rdata;
  assign bus.uart_rx_ready = !rx_full;
  assign bus.uart_tx_data  = tx_data;
  assign bus.uart_tx_valid = (tx_state == TX_FULL);
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based transaction model of the register map.
module tb_mmio_io_ctrl;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmio_io_ctrl_if bus();

  mmio_io_ctrl #(.RX_FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0]  m_q[$];
  logic        m_tx_full;
  logic [7:0]  m_tx_data;
  logic [31:0] m_rdata, m_cyc, m_inst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_tx_full = 1'b0;
    m_tx_data = '0;
    m_rdata   = '0;
    m_cyc     = '0;
    m_inst    = '0;
  endfunction

  function automatic void model_edge();
    logic room;
    logic was_full;
    room     = (m_q.size() < DEPTH);
    was_full = m_tx_full;
    if (bus.mmio_re) begin
      case (bus.mmio_addr)
        BASE + 32'h00: m_rdata = {30'b0, (m_q.size() != 0), !m_tx_full};
        BASE + 32'h04: m_rdata = (m_q.size() != 0) ? {24'b0, m_q.pop_front()} : 32'h0;
        BASE + 32'h10: m_rdata = m_cyc;
        BASE + 32'h14: m_rdata = m_inst;
        default:       m_rdata = 32'h0;
      endcase
    end
    if (bus.uart_rx_valid && room) m_q.push_back(bus.uart_rx_data);
    if (was_full && bus.uart_tx_ready) m_tx_full = 1'b0;
    if (bus.mmio_we && bus.mmio_addr == BASE + 32'h08 && !was_full) begin
      m_tx_full = 1'b1;
      m_tx_data = bus.mmio_wdata[7:0];
    end
    if (bus.mmio_we && bus.mmio_addr == BASE + 32'h18) begin
      m_cyc  = 32'h0;
      m_inst = 32'h0;
    end else begin
      m_cyc  = m_cyc + 32'd1;
      m_inst = m_inst + (bus.inst_retired ? 32'd1 : 32'd0);
    end
  endfunction

  task automatic check_outputs();
    check("rdata",    bus.mmio_rdata, m_rdata);
    check("tx_valid", {31'b0, bus.uart_tx_valid}, {31'b0, m_tx_full});
    check("tx_data",  {24'b0, bus.uart_tx_data}, {24'b0, m_tx_data});
    check("rx_ready", {31'b0, bus.uart_rx_ready}, (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic bus_op(input logic re, input logic we, input logic [31:0] ofs, input logic [31:0] wd);
    bus.mmio_re    = re;
    bus.mmio_we    = we;
    bus.mmio_addr  = BASE + ofs;
    bus.mmio_wdata = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ofs;
    int unsigned k;

    bus_op(1'b0, 1'b0, 32'h0, 32'h0);
    bus.inst_retired  = 1'b0;
    bus.uart_rx_data  = '0;
    bus.uart_rx_valid = 1'b0;
    bus.uart_tx_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    check("reset_rx_ready", {31'b0, bus.uart_rx_ready}, 32'd1);
    do_reset();

    // Status after reset
    bus_op(1'b1, 1'b0, 32'h00, 32'h0); step();
    check("status_reset", bus.mmio_rdata, 32'h1);
    bus_op(1'b0, 1'b0, 32'h0, 32'h0);

    // Two RX bytes, read back in order, then read an empty FIFO
    bus.uart_rx_valid = 1'b1; bus.uart_rx_data = 8'h41; step();
    bus.uart_rx_data = 8'h42; step();
    bus.uart_rx_valid = 1'b0;
    bus_op(1'b1, 1'b0, 32'h00, 32'h0); step(); check("status_rx", bus.mmio_rdata, 32'h3);
    bus_op(1'b1, 1'b0, 32'h04, 32'h0); step(); check("rx_41", bus.mmio_rdata, 32'h41);
    step(); check("rx_42", bus.mmio_rdata, 32'h42);
    bus_op(1'b1, 1'b0, 32'h00, 32'h0); step(); check("status_drained", bus.mmio_rdata, 32'h1);
    bus_op(1'b1, 1'b0, 32'h04, 32'h0); step(); check("rx_empty_read", bus.mmio_rdata, 32'h0);
    bus_op(1'b0, 1'b0, 32'h0, 32'h0); step();

    // Fill the FIFO, hold a ninth byte, pop once and let it in
    bus.uart_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx_data = 8'h10 + 8'(i);
      step();
    end
    check("full_ready", {31'b0, bus.uart_rx_ready}, 32'd0);
    bus.uart_rx_data = 8'h18; step();
    check("full_hold", {31'b0, bus.uart_rx_ready}, 32'd0);
    bus_op(1'b1, 1'b0, 32'h04, 32'h0); step();
    check("full_pop", bus.mmio_rdata, 32'h10);
    check("ready_after_pop", {31'b0, bus.uart_rx_ready}, 32'd1);
    bus_op(1'b0, 1'b0, 32'h0, 32'h0); step();
    bus.uart_rx_valid = 1'b0;
    bus_op(1'b1, 1'b0, 32'h04, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("drain_seq", bus.mmio_rdata, 32'h10 + 32'(i));
    end
    bus_op(1'b0, 1'b0, 32'h0, 32'h0); step();

    // TX holding register: held while not ready, second write dropped
    bus.uart_tx_ready = 1'b0;
    bus_op(1'b0, 1'b1, 32'h08, 32'h0000_1255); step();
    bus_op(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus_op(1'b0, 1'b1, 32'h08, 32'hAA);
      else        bus_op(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("tx_hold_valid", {31'b0, bus.uart_tx_valid}, 32'd1);
      check("tx_hold_data", {24'b0, bus.uart_tx_data}, 32'h55);
    end
    bus_op(1'b0, 1'b0, 32'h0, 32'h0);
    bus.uart_tx_ready = 1'b1; step();
    bus.uart_tx_ready = 1'b0;
    check("tx_done", {31'b0, bus.uart_tx_valid}, 32'd0);
    bus_op(1'b1, 1'b0, 32'h00, 32'h0); step(); check("status_tx_empty", bus.mmio_rdata, 32'h1);
    bus_op(1'b0, 1'b1, 32'h08, 32'h66); step();
    bus_op(1'b0, 1'b1, 32'h08, 32'h77); bus.uart_tx_ready = 1'b1; step();
    bus.uart_tx_ready = 1'b0;
    check("tx_race_drop", {31'b0, bus.uart_tx_valid}, 32'd0);
    check("tx_race_data", {24'b0, bus.uart_tx_data}, 32'h66);
    bus_op(1'b0, 1'b0, 32'h0, 32'h0);

    // Counters from a fresh reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.inst_retired = (i == 1 || i == 4 || i == 7);
      step();
    end
    bus.inst_retired = 1'b0;
    bus_op(1'b1, 1'b0, 32'h14, 32'h0); step(); check("inst_cnt_3", bus.mmio_rdata, 32'd3);
    bus_op(1'b1, 1'b0, 32'h10, 32'h0); step(); check("cycle_cnt_11", bus.mmio_rdata, 32'd11);
    bus_op(1'b0, 1'b1, 32'h18, 32'h0); bus.inst_retired = 1'b1; step();
    bus.inst_retired = 1'b0;
    bus_op(1'b1, 1'b0, 32'h14, 32'h0); step(); check("inst_cleared", bus.mmio_rdata, 32'd0);
    bus_op(1'b1, 1'b0, 32'h10, 32'h0); step(); check("cycle_resumed", bus.mmio_rdata, 32'd1);

    // Cycle counter wrap
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    release dut.cycle_cnt;
    m_cyc = 32'hFFFF_FFFF;
    step(); check("cycle_max", bus.mmio_rdata, 32'hFFFF_FFFF);
    step(); check("cycle_wrap", bus.mmio_rdata, 32'h0);
    bus_op(1'b0, 1'b0, 32'h0, 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 7))
        0: ofs = 32'h00;
        1: ofs = 32'h04;
        2: ofs = 32'h08;
        3: ofs = 32'h10;
        4: ofs = 32'h14;
        5: ofs = ($urandom_range(0, 3) == 0) ? 32'h18 : 32'h04;
        6: ofs = 32'h0C;
        default: ofs = 32'($urandom_range(0, 255));
      endcase
      bus_op(k < 4, (k >= 4 && k < 7), ofs, $urandom);
      bus.uart_rx_valid = $urandom_range(0, 1) == 1;
      bus.uart_rx_data  = 8'($urandom);
      bus.uart_tx_ready = $urandom_range(0, 3) == 0;
      bus.inst_retired  = $urandom_range(0, 1) == 1;
      step();
    end

    // Asynchronous reset in the middle of a TX handshake
    bus_op(1'b0, 1'b0, 32'h0, 32'h0);
    bus.uart_tx_ready = 1'b0;
    bus.inst_retired  = 1'b0;
    bus.uart_rx_valid = 1'b0;
    step();
    bus_op(1'b0, 1'b1, 32'h08, 32'h3C);
    bus.uart_rx_valid = 1'b1; bus.uart_rx_data = 8'h99;
    step();
    bus_op(1'b0, 1'b0, 32'h0, 32'h0);
    bus.uart_rx_valid = 1'b0;
    check("pre_rst_valid", {31'b0, bus.uart_tx_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_tx_valid", {31'b0, bus.uart_tx_valid}, 32'd0);
    check("async_rx_ready", {31'b0, bus.uart_rx_ready}, 32'd1);
    check("async_rdata", bus.mmio_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_op(1'b1, 1'b0, 32'h00, 32'h0); step(); check("status_after_rst", bus.mmio_rdata, 32'h1);
    bus_op(1'b0, 1'b0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O block directly downstream of the core's memory stage. Decodes the 0x8000_00xx address window and services loads and stores to it.
- Bridges core accesses to the on-chip UART's ready/valid byte interfaces: RX bytes are buffered in a FIFO, TX bytes go through a one-entry holding register.
- Also provides cycle and retired-instruction counters.
- Read data is registered, giving 1-cycle latency to match DMEM/BIOS so the writeback mux treats all three sources identically.

Parameters:
- RX_FIFO_DEPTH, 8, RX byte FIFO entries; power of two, at least 2.
- MMIO_BASE, 32'h8000_0000, base address of the register window.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- mmio_addr  in  32  byte address from the execute-stage ALU result.
- mmio_wdata  in  32  store data, already lane-aligned.
- mmio_we  in  1  store strobe; asserted only for addresses in the window.
- mmio_re  in  1  load strobe; asserted only for addresses in the window.
- inst_retired  in  1  one pulse per instruction leaving writeback.
- mmio_rdata  out  32  registered load data.
- uart_rx_data  in  8  byte from UART receiver.
- uart_rx_valid  in  1  receiver byte valid.
- uart_rx_ready  out  1  this block can accept an RX byte.
- uart_tx_data  out  8  byte to UART transmitter.
- uart_tx_valid  out  1  TX byte valid.
- uart_tx_ready  in  1  transmitter ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - mmio_rdata=0, uart_tx_valid=0, uart_tx_data=0.
  - RX FIFO empty, so uart_rx_ready=1.
  - cycle_cnt=0, inst_cnt=0.
- Register map (offset from MMIO_BASE, full 32-bit compare):
  - 0x00 status (RO): bit0 = TX holding register empty; bit1 = RX FIFO non-empty; other bits 0.
  - 0x04 rx_data (RO, read pops): {24'b0, head byte}. Returns 0 with no pop if the FIFO is empty.
  - 0x08 tx_data (WO): wdata[7:0] is loaded into the TX holding register.
  - 0x10 cycle_cnt (RO).
  - 0x14 inst_cnt (RO).
  - 0x18 counter_reset (WO): any write clears both counters.
  - Any other offset: reads return 0; writes are ignored.
- Read timing:
  - mmio_rdata is sampled at the posedge where mmio_re=1 and is valid the following cycle.
  - It holds its value while mmio_re=0.
  - Status and counter reads return the pre-edge values.
- RX FIFO:
  - uart_rx_ready = !full.
  - A push occurs when uart_rx_valid && uart_rx_ready.
  - A pop occurs when an rx_data read hits a non-empty FIFO.
  - Push and pop in the same cycle when non-empty: both take effect and the count is unchanged.
  - Empty FIFO with a push and an rx_data read in the same cycle: the read returns 0, nothing is popped, and the push is stored.
  - Full FIFO: no push (ready is low), so the UART retains its byte; a pop in that cycle frees an entry and ready rises the next cycle.
  - Pointers wrap modulo RX_FIFO_DEPTH. Occupancy is tracked with an extra pointer bit or a counter so full and empty are unambiguous.
- TX path:
  - A write to 0x08 is accepted only when the holding register is empty, i.e. uart_tx_valid=0 at that edge.
  - On acceptance, uart_tx_data is loaded and uart_tx_valid=1 from the next cycle.
  - uart_tx_valid stays high, with data stable, until uart_tx_ready is seen high at an edge; it clears at that edge.
  - A write while full is dropped silently. Software polls status bit0 first.
  - A write in the same cycle as the handshake completes is dropped, because valid was still 1 at that edge.
- Counters:
  - 32-bit, wrap 0xFFFF_FFFF -> 0.
  - cycle_cnt increments every cycle out of reset.
  - inst_cnt increments when inst_retired=1.
  - counter_reset has priority: after the clearing edge both counters read 0, and the increment for that cycle is discarded.
- mmio_we and mmio_re both asserted is illegal; behaviour in that case is unspecified.

Test Plan:
- Reset, then read 0x00 -> rdata=0x0000_0001 one cycle later; uart_rx_ready=1 and uart_tx_valid=0.
- UART pushes 0x41 then 0x42; read 0x00 -> 0x3. Read 0x04 twice -> 0x41 then 0x42. Read 0x00 -> 0x1. A third read of 0x04 -> 0x0.
- Push 8 bytes 0x10..0x17 -> uart_rx_ready=0 after the 8th push; a 9th byte is held by the UART. One pop -> ready=1 next cycle, the 9th byte is accepted, and the remaining reads return 0x11..0x18 in order.
- Write 0x08 with 0x55 while uart_tx_ready=0 for 5 cycles -> uart_tx_valid=1 with data 0x55 held stable. Write 0xAA during this -> dropped. After uart_tx_ready=1 for one edge -> valid=0 and status bit0=1.
- Pulse inst_retired 3 times over 10 cycles after reset, then read 0x14 -> 3. Read 0x10 -> equals cycle count at the sampling edge. Write 0x18 -> both counters read 0 and 1 respectively on the next reads (cycle counter resumes).
- Force cycle_cnt to 0xFFFF_FFFF -> reads 0 one cycle later. Assert rst_n low mid TX handshake -> uart_tx_valid drops immediately (asynchronously) and the FIFO is empty.
